// File: rtl/instr_register_ctrl.sv
// Arbitrates one writer and one reader onto the 32-entry instr_register as a FIFO; grant one cycle after a request is sampled, data two.
// Backpressure: requests are held until granted; writes stall while full, reads stall while empty, and flush pre-empts both.
module instr_register_ctrl #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 4,
    parameter int OPND_W = 32,
    parameter int RES_W  = 64,
    parameter int IW_W   = OPC_W + 2*OPND_W + RES_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [OPC_W-1:0]  wr_opcode,
    input  logic [OPND_W-1:0] wr_op_a,
    input  logic [OPND_W-1:0] wr_op_b,
    output logic              wr_gnt,
    input  logic              rd_req,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [OPC_W-1:0]  rd_opcode,
    output logic [OPND_W-1:0] rd_op_a,
    output logic [OPND_W-1:0] rd_op_b,
    output logic [RES_W-1:0]  rd_result,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              reg_reset_n,
    output logic              load_en,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPND_W-1:0] operand_a,
    output logic [OPND_W-1:0] operand_b,
    output logic [ADDR_W-1:0] write_pointer,
    output logic [ADDR_W-1:0] read_pointer,
    input  logic [IW_W-1:0]   instruction_word
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                last_wr_q, last_wr_d;
    logic                flush_q, flush_d, flush_cnt_q, flush_cnt_d;
    logic                wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic                rd_valid_q, rd_valid_d, load_en_q, load_en_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d, rd_opcode_q, rd_opcode_d;
    logic [OPND_W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [OPND_W-1:0]   rd_op_a_q, rd_op_a_d, rd_op_b_q, rd_op_b_d;
    logic [RES_W-1:0]    rd_result_q, rd_result_d;
    logic [ADDR_W-1:0]   write_pointer_q, write_pointer_d, read_pointer_q, read_pointer_d;
    logic                wr_ok, rd_ok;

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = wr_req && !full;
    assign rd_ok = rd_req && !empty;

    always_comb begin
        state_d         = state_q;
        wp_d            = wp_q;
        rp_d            = rp_q;
        count_d         = count_q;
        last_wr_d       = last_wr_q;
        flush_d         = flush_q;
        flush_cnt_d     = flush_cnt_q;
        wr_gnt_d        = 1'b0;
        rd_gnt_d        = 1'b0;
        rd_valid_d      = 1'b0;
        load_en_d       = 1'b0;
        opcode_d        = opcode_q;
        opa_d           = opa_q;
        opb_d           = opb_q;
        rd_opcode_d     = rd_opcode_q;
        rd_op_a_d       = rd_op_a_q;
        rd_op_b_d       = rd_op_b_q;
        rd_result_d     = rd_result_q;
        write_pointer_d = write_pointer_q;
        read_pointer_d  = read_pointer_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d     = S_FLUSH;
                    flush_d     = 1'b1;
                    flush_cnt_d = 1'b0;
                // Round-robin: a contested write only wins if the previous grant went to the reader.
                end else if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    state_d         = S_WRITE;
                    wr_gnt_d        = 1'b1;
                    load_en_d       = 1'b1;
                    opcode_d        = wr_opcode;
                    opa_d           = wr_op_a;
                    opb_d           = wr_op_b;
                    write_pointer_d = wp_q;
                end else if (rd_ok) begin
                    state_d        = S_READ;
                    rd_gnt_d       = 1'b1;
                    read_pointer_d = rp_q;
                end
            end
            S_WRITE: begin
                wp_d      = wp_q + ADDR_W'(1);
                count_d   = count_q + (ADDR_W+1)'(1);
                last_wr_d = 1'b1;
                state_d   = S_IDLE;
            end
            S_READ: begin
                rd_opcode_d = instruction_word[IW_W-1 -: OPC_W];
                rd_op_a_d   = instruction_word[2*OPND_W+RES_W-1 -: OPND_W];
                rd_op_b_d   = instruction_word[OPND_W+RES_W-1 -: OPND_W];
                rd_result_d = instruction_word[RES_W-1:0];
                rd_valid_d  = 1'b1;
                rp_d        = rp_q + ADDR_W'(1);
                count_d     = count_q - (ADDR_W+1)'(1);
                last_wr_d   = 1'b0;
                state_d     = S_IDLE;
            end
            S_FLUSH: begin
                if (flush_cnt_q) begin
                    flush_d         = 1'b0;
                    wp_d            = '0;
                    rp_d            = '0;
                    count_d         = '0;
                    write_pointer_d = '0;
                    read_pointer_d  = '0;
                    state_d         = S_IDLE;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wp_q            <= '0;
            rp_q            <= '0;
            count_q         <= '0;
            last_wr_q       <= 1'b0;
            flush_q         <= 1'b0;
            flush_cnt_q     <= 1'b0;
            wr_gnt_q        <= 1'b0;
            rd_gnt_q        <= 1'b0;
            rd_valid_q      <= 1'b0;
            load_en_q       <= 1'b0;
            opcode_q        <= '0;
            opa_q           <= '0;
            opb_q           <= '0;
            rd_opcode_q     <= '0;
            rd_op_a_q       <= '0;
            rd_op_b_q       <= '0;
            rd_result_q     <= '0;
            write_pointer_q <= '0;
            read_pointer_q  <= '0;
        end else begin
            state_q         <= state_d;
            wp_q            <= wp_d;
            rp_q            <= rp_d;
            count_q         <= count_d;
            last_wr_q       <= last_wr_d;
            flush_q         <= flush_d;
            flush_cnt_q     <= flush_cnt_d;
            wr_gnt_q        <= wr_gnt_d;
            rd_gnt_q        <= rd_gnt_d;
            rd_valid_q      <= rd_valid_d;
            load_en_q       <= load_en_d;
            opcode_q        <= opcode_d;
            opa_q           <= opa_d;
            opb_q           <= opb_d;
            rd_opcode_q     <= rd_opcode_d;
            rd_op_a_q       <= rd_op_a_d;
            rd_op_b_q       <= rd_op_b_d;
            rd_result_q     <= rd_result_d;
            write_pointer_q <= write_pointer_d;
            read_pointer_q  <= read_pointer_d;
        end
    end

    // The register is held in reset both by the global reset and for the two flush cycles.
    assign reg_reset_n   = ~(reset | flush_q);
    assign flush_busy    = flush_q;
    assign count         = count_q;
    assign wr_gnt        = wr_gnt_q;
    assign rd_gnt        = rd_gnt_q;
    assign rd_valid      = rd_valid_q;
    assign load_en       = load_en_q;
    assign opcode        = opcode_q;
    assign operand_a     = opa_q;
    assign operand_b     = opb_q;
    assign rd_opcode     = rd_opcode_q;
    assign rd_op_a       = rd_op_a_q;
    assign rd_op_b       = rd_op_b_q;
    assign rd_result     = rd_result_q;
    assign write_pointer = write_pointer_q;
    assign read_pointer  = read_pointer_q;

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Bench for instr_register_ctrl: a behavioural register array plus a FIFO queue model of the stored instructions.
module tb_instr_register_ctrl;
    localparam int DEPTH = 32, ADDR_W = 5, OPC_W = 4, OPND_W = 32, RES_W = 64;
    localparam int IW_W = OPC_W + 2*OPND_W + RES_W;
    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MULT = 4'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_req = 1'b0, rd_req = 1'b0, flush_req = 1'b0;
    logic [OPC_W-1:0]  wr_opcode = '0;
    logic [OPND_W-1:0] wr_op_a = '0, wr_op_b = '0;
    logic wr_gnt, rd_gnt, rd_valid, flush_busy, full, empty, reg_reset_n, load_en;
    logic [OPC_W-1:0]  rd_opcode, opcode;
    logic [OPND_W-1:0] rd_op_a, rd_op_b, operand_a, operand_b;
    logic [RES_W-1:0]  rd_result;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] write_pointer, read_pointer;
    logic [IW_W-1:0]   instruction_word;

    always #5 clk = ~clk;

    instr_register_ctrl dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_opcode(wr_opcode), .wr_op_a(wr_op_a), .wr_op_b(wr_op_b), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_opcode(rd_opcode), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b), .rd_result(rd_result),
        .flush_req(flush_req), .flush_busy(flush_busy), .count(count), .full(full), .empty(empty),
        .reg_reset_n(reg_reset_n), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word)
    );

    function automatic logic [63:0] alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            OP_ADD:  return sa + sb;
            OP_SUB:  return sa - sb;
            OP_MULT: return sa * sb;
            default: return 64'd0;
        endcase
    endfunction

    // Stand-in for instr_register: captures on load_en, combinational read.
    logic [IW_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!reg_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load_en) begin
            mem[write_pointer] <= {opcode, operand_a, operand_b, alu(opcode, operand_a, operand_b)};
        end
    end
    assign instruction_word = mem[read_pointer];

    typedef struct { logic [3:0] opc; logic [31:0] a; logic [31:0] b; } ent_t;
    ent_t q[$];
    int total = 0, bad = 0;
    int exp_cnt = 0, exp_wp = 0, exp_rp = 0, n_wr = 0, n_rd = 0;
    bit last_w = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        #1;
        if (reset) return;
        if (!flush_busy) begin
            chk("count", count, exp_cnt);
            chk("full", full, exp_cnt == DEPTH);
            chk("empty", empty, exp_cnt == 0);
        end
        chk("gnt_exclusive", wr_gnt & rd_gnt, 0);
        chk("load_en_with_gnt", load_en, wr_gnt);
        if (rd_valid) begin
            if (q.size() == 0) begin
                chk("rd_valid_unexpected", rd_valid, 0);
            end else begin
                e = q.pop_front();
                chk("rd_opcode", rd_opcode, e.opc);
                chk("rd_op_a", rd_op_a, e.a);
                chk("rd_op_b", rd_op_b, e.b);
                chk("rd_result", rd_result, alu(e.opc, e.a, e.b));
            end
        end
        if (wr_gnt) begin
            chk("write_pointer", write_pointer, exp_wp);
            chk("opcode_out", opcode, wr_opcode);
            chk("operand_a_out", operand_a, wr_op_a);
            chk("operand_b_out", operand_b, wr_op_b);
            e.opc = wr_opcode; e.a = wr_op_a; e.b = wr_op_b;
            q.push_back(e);
            exp_cnt++;
            exp_wp = (exp_wp + 1) % DEPTH;
            last_w = 1'b1;
            n_wr++;
        end
        if (rd_gnt) begin
            chk("read_pointer", read_pointer, exp_rp);
            exp_cnt--;
            exp_rp = (exp_rp + 1) % DEPTH;
            last_w = 1'b0;
            n_rd++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0; flush_req = 1'b0;
        #1;
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_reg_reset_n", reg_reset_n, 0);
        chk("rst_load_en", load_en, 0);
        chk("rst_wptr", write_pointer, 0);
        chk("rst_rptr", read_pointer, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_rd_result", rd_result, 0);
        q.delete();
        exp_cnt = 0; exp_wp = 0; exp_rp = 0; last_w = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_release_reg_reset_n", reg_reset_n, 1);
    endtask

    task automatic wait_wr();
        int start = n_wr;
        for (int i = 0; i < 20 && n_wr == start; i++) tick();
        chk("wr_gnt_timeout", n_wr, start + 1);
    endtask

    task automatic wait_rd();
        int start = n_rd;
        for (int i = 0; i < 20 && n_rd == start; i++) tick();
        chk("rd_gnt_timeout", n_rd, start + 1);
    endtask

    task automatic do_write(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        wr_opcode = o; wr_op_a = a; wr_op_b = b;
        wr_req = 1'b1;
        wait_wr();
        wr_req = 1'b0;
        tick();
    endtask

    task automatic do_read();
        rd_req = 1'b1;
        wait_rd();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic rand_write();
        do_write(4'($urandom_range(0, 3)), $urandom, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, g;
        bit pl;

        // Directed write/read of three entries.
        do_reset();
        tick();
        do_write(OP_ADD, 32'd5, 32'd3);
        do_write(OP_SUB, -32'sd7, 32'd2);
        do_write(OP_MULT, 32'd4, 32'd4);
        chk("count_after_3w", count, 3);
        do_read();
        do_read();
        do_read();
        chk("empty_after_3r", empty, 1);

        // Round-robin with both requests held at count=2.
        do_reset();
        rand_write(); rand_write(); rand_write();
        do_read();
        chk("count_before_rr", count, 2);
        wr_opcode = 4'($urandom_range(0, 3)); wr_op_a = $urandom; wr_op_b = $urandom;
        wr_req = 1'b1; rd_req = 1'b1;
        g = 0;
        for (int i = 0; i < 40 && g < 8; i++) begin
            pl = last_w;
            tick();
            if (wr_gnt || rd_gnt) begin
                chk("rr_order", wr_gnt, !pl);
                g++;
                if (wr_gnt) begin
                    wr_opcode = 4'($urandom_range(0, 3)); wr_op_a = $urandom; wr_op_b = $urandom;
                end
            end
        end
        chk("rr_grant_count", g, 8);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(); tick();

        // Fill to full, stall a write, release it with one read.
        do_reset();
        for (int i = 0; i < DEPTH; i++) rand_write();
        chk("full_at_32", full, 1);
        wr_opcode = OP_SUB; wr_op_a = $urandom; wr_op_b = $urandom;
        wr_req = 1'b1;
        start = n_wr;
        for (int i = 0; i < 10; i++) tick();
        chk("no_wr_gnt_when_full", n_wr, start);
        rd_req = 1'b1;
        wait_rd();
        rd_req = 1'b0;
        wait_wr();
        chk("wrap_write_pointer", write_pointer, 0);
        wr_req = 1'b0;
        tick();
        chk("count_back_32", count, 32);

        // Read while empty, then satisfied by a later write.
        do_reset();
        rd_req = 1'b1;
        start = n_rd;
        for (int i = 0; i < 5; i++) tick();
        chk("no_rd_gnt_when_empty", n_rd, start);
        do_write(OP_ADD, $urandom, $urandom);
        do_read();

        // Flush with five entries and a write pending.
        do_reset();
        for (int i = 0; i < 5; i++) rand_write();
        wr_opcode = OP_MULT; wr_op_a = $urandom; wr_op_b = $urandom;
        wr_req = 1'b1; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("flush_busy_c1", flush_busy, 1);
        chk("flush_rrn_c1", reg_reset_n, 0);
        q.delete();
        exp_cnt = 0; exp_wp = 0; exp_rp = 0;
        tick();
        chk("flush_busy_c2", flush_busy, 1);
        chk("flush_rrn_c2", reg_reset_n, 0);
        tick();
        chk("flush_busy_done", flush_busy, 0);
        chk("flush_rrn_done", reg_reset_n, 1);
        chk("flush_count", count, 0);
        chk("flush_wptr", write_pointer, 0);
        chk("flush_rptr", read_pointer, 0);
        wait_wr();
        chk("post_flush_slot", write_pointer, 0);
        wr_req = 1'b0;
        tick();
        do_read();

        // Reset asserted while a read is in flight.
        do_reset();
        rand_write();
        rd_req = 1'b1;
        wait_rd();
        #2;
        do_reset();
        start = n_rd;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_rd_valid_after_reset", rd_valid, 0);
        end
        chk("no_rd_gnt_after_reset", n_rd, start);
        chk("count_after_reset", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_register_ctrl.md
Name: instr_register_ctrl

Overview:
- Sequencing and arbitration controller for the 32-entry instruction register (instr_register).
- Shares the register between one write requester and one read requester, performing one access at a time.
- Allocates write_pointer and read_pointer in FIFO order, so the register behaves as a 32-deep instruction queue.
- Tracks occupancy and performs a flush by pulsing the register's active-low reset. Sits between the stimulus/ALU-issue logic and instr_register.

Parameters:
DEPTH, 32, number of register entries (power of 2)
ADDR_W, 5, pointer width, log2(DEPTH)
OPC_W, 4, opcode width
OPND_W, 32, operand width (signed)
RES_W, 64, result width
IW_W, OPC_W+2*OPND_W+RES_W, instruction_word width {opc, op_a, op_b, result}

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_req  in  1  write request, held until wr_gnt
wr_opcode  in  OPC_W  opcode to store
wr_op_a  in  OPND_W  operand a (signed)
wr_op_b  in  OPND_W  operand b (signed)
wr_gnt  out  1  one-cycle write-accepted pulse
rd_req  in  1  read request, held until rd_gnt
rd_gnt  out  1  one-cycle read-accepted pulse
rd_valid  out  1  one-cycle pulse; rd_* fields valid
rd_opcode  out  OPC_W  read opcode
rd_op_a  out  OPND_W  read operand a
rd_op_b  out  OPND_W  read operand b
rd_result  out  RES_W  read result
flush_req  in  1  clear queue and register contents
flush_busy  out  1  high while flushing
count  out  ADDR_W+1  entries held, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
reg_reset_n  out  1  to instr_register reset_n
load_en  out  1  to instr_register load_en
opcode  out  OPC_W  to instr_register opcode
operand_a  out  OPND_W  to instr_register operand_a
operand_b  out  OPND_W  to instr_register operand_b
write_pointer  out  ADDR_W  to instr_register write_pointer
read_pointer  out  ADDR_W  to instr_register read_pointer
instruction_word  in  IW_W  from instr_register; combinational read of read_pointer

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: every output is 0, except empty=1 and reg_reset_n=0.
  - reg_reset_n = ~(reset | flush_active), with flush_active registered.
  - Internal pointers wp and rp reset to 0, last_grant_wr to 0, state to IDLE.
- FSM states: IDLE, WRITE, READ, FLUSH.
- IDLE: arbitrate on the sampled inputs, in this priority order:
  - flush_req -> FLUSH.
  - wr_req&!full and rd_req&!empty both set -> round-robin. Write wins if last_grant_wr==0, otherwise read wins.
  - Only wr_req&!full set -> WRITE.
  - Only rd_req&!empty set -> READ.
  - Write when full, or read when empty -> no grant. Stay in IDLE; the request remains pending with no error.
- On IDLE->WRITE: register opcode/operand_a/operand_b from wr_*, write_pointer<=wp, load_en<=1.
- WRITE (1 cycle): wr_gnt=1. instr_register captures at the closing edge. At that edge:
  - load_en<=0
  - wp<=wp+1, wrapping DEPTH-1->0
  - count<=count+1
  - last_grant_wr<=1
  - ->IDLE
- On IDLE->READ: read_pointer<=rp.
- READ (1 cycle): rd_gnt=1. At the closing edge:
  - capture instruction_word into rd_*
  - rd_valid<=1 for one cycle
  - rp<=rp+1, wrapping
  - count<=count-1
  - last_grant_wr<=0
  - ->IDLE
- Latency: write is visible in the register 2 edges after wr_req is sampled in IDLE. rd_valid is asserted 2 cycles after rd_req is sampled. Maximum throughput is one access per 2 cycles.
- read_pointer and rd_* hold their last values between reads. write_pointer and the operands hold between writes.
- FLUSH: lasts exactly 2 cycles, with flush_busy=1 and flush_active=1, so reg_reset_n is low for 2 cycles. On exit:
  - wp=rp=0, count=0
  - write_pointer=read_pointer=0
  - ->IDLE
  - Requests pending during FLUSH are not granted and are re-arbitrated in IDLE.
- count is updated only in WRITE/READ, so it never exceeds DEPTH or underflows.
- full and empty are combinational from count.
- Asynchronous reset mid-WRITE/READ/FLUSH: immediate return to the reset values. The interrupted access is not counted and no gnt/rd_valid is produced after reset release.
- The requester must deassert or change its req in the cycle after it sees gnt. A req still high in IDLE is treated as a new request.

Test Plan:
- Reset, then write 3 entries (opc=ADD, a=5, b=3; opc=SUB, a=-7, b=2; opc=MULT, a=4, b=4) -> write_pointer 0,1,2 with load_en one cycle each; count=3; read 3 -> rd_valid with same fields in order, read_pointer 0,1,2, empty=1.
- Hold wr_req and rd_req together with count=2 -> grants alternate W,R,W,R starting with W after reset; count oscillates 3,2,3,2.
- Write 32 entries -> full=1; 33rd wr_req gets no wr_gnt for 10 cycles; one read -> pending write granted at write_pointer=0 (wrap); count returns to 32.
- Read with empty=1 for 5 cycles -> no rd_gnt/rd_valid; a subsequent write to slot 0 -> read is then granted and returns it.
- Flush with count=5 and wr_req pending -> reg_reset_n low exactly 2 cycles, flush_busy=1; count=0, pointers 0; then write granted at slot 0.
- Assert reset during READ -> rd_valid never pulses, count unchanged from reset value 0, all outputs at reset values.
